// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI data width and arbiter FSM state encoding
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority picker; req/ptr in, gnt_valid/gnt_id out, lane ptr+1 searched first
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] idx;
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id = idx;
      end
    end
  end
endmodule

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin packet-locked SPI tx sharing; req_* lanes in, req_ready/done/err/grant_id/active out, m_tx_req/m_tx_data/m_busy to master
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*SPI_DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          active,
  output logic                          m_tx_req,
  output logic [SPI_DATA_W-1:0]         m_tx_data,
  input  logic                          m_busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_t state;
  logic [IW-1:0] ptr, gnt_id;
  logic gnt_valid, last;
  logic [CW-1:0] cnt;
  logic [SPI_DATA_W-1:0] lane_data [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_data[i] = req_data[i*SPI_DATA_W +: SPI_DATA_W];
  end
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(req_valid),
    .ptr(ptr),
    .gnt_valid(gnt_valid),
    .gnt_id(gnt_id)
  );
  assign active = state != IDLE;
  assign m_tx_req = state == ISSUE;
  always_comb
    req_ready = !rst ? '0 :
                (state == IDLE && gnt_valid) ? NUM_REQ'(1) << gnt_id :
                (state == HOLD && req_valid[grant_id]) ? NUM_REQ'(1) << grant_id : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= IW'(NUM_REQ - 1);
      grant_id <= '0;
      m_tx_data <= '0;
      last <= 1'b0;
      cnt <= '0;
      done <= '0;
      err <= 1'b0;
    end else begin
      done <= '0;
      err <= 1'b0;
      case (state)
        IDLE: if (gnt_valid) begin
          grant_id <= gnt_id;
          m_tx_data <= lane_data[gnt_id];
          last <= req_last[gnt_id];
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (m_busy) state <= WAIT_DONE;
        else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          cnt <= CW'(TIMEOUT_CYC);
          err <= 1'b1;
          ptr <= grant_id;
          state <= IDLE;
        end else cnt <= cnt + CW'(1);
        WAIT_DONE: if (!m_busy) begin
          done[grant_id] <= 1'b1;
          if (last) ptr <= grant_id;
          state <= last ? IDLE : HOLD;
        end
        HOLD: if (req_valid[grant_id]) begin
          m_tx_data <= lane_data[grant_id];
          last <= req_last[grant_id];
          state <= ISSUE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: table-driven and scoreboarded bench for spi_tx_arbiter with a busy-flag master model
module tb_spi_tx_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready, done;
  logic [N*8-1:0] req_data = '0;
  logic err, active, m_tx_req, m_busy = 1'b0;
  logic [1:0] grant_id;
  logic [7:0] m_tx_data;
  int total = 0, bad = 0, busy_len = 3, bl = 0, n = 0, dn = 0;
  bit model_on = 1'b1;
  typedef struct packed {logic [1:0] lane; logic [7:0] data;} txn_t;
  txn_t sb[$];
  txn_t e;
  typedef struct {logic [3:0] valid; logic [31:0] data; int exp_lane;} vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  spi_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .done(done), .err(err), .grant_id(grant_id), .active(active),
    .m_tx_req(m_tx_req), .m_tx_data(m_tx_data), .m_busy(m_busy)
  );

  always @(posedge clk) begin
    if (!rst || !model_on) bl = 0;
    else if (m_tx_req) bl = busy_len;
    else if (bl > 0) bl--;
    #1 m_busy = bl > 0;
  end

  always @(posedge clk) begin
    #4;
    if (rst && m_tx_req) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL tx_req_extra: got lane %0d data %0h expected no request", grant_id, m_tx_data);
      end else begin
        e = sb.pop_front();
        if ({grant_id, m_tx_data} !== {e.lane, e.data}) begin
          bad++;
          $display("FAIL tx_req_data: got lane %0d data %0h expected lane %0d data %0h", grant_id, m_tx_data, e.lane, e.data);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [3:0] oh(int l);
    return 4'(1) << l;
  endfunction

  task automatic set_lane(int l, logic v, logic [7:0] d, logic lst);
    req_valid[l] = v;
    req_data[8*l +: 8] = d;
    req_last[l] = lst;
  endtask

  task automatic accept(int l, string name);
    #1;
    chk(name, req_ready, oh(l));
    sb.push_back({2'(l), req_data[8*l +: 8]});
  endtask

  task automatic wait_done(int l, int max, output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (done == 0 && cnt < max);
    chk("done_lane", done, oh(l));
  endtask

  task automatic xfer(int l, logic [7:0] d, logic lst, int max);
    int k = 0;
    logic others = 1'b0;
    set_lane(l, 1'b1, d, lst);
    #1;
    while (!req_ready[l] && k < max) begin
      if ((req_ready & ~oh(l)) != 0) others = 1'b1;
      cyc();
      #1;
      k++;
    end
    chk("lock_others", 32'(others), 0);
    chk("hold_ready", req_ready, oh(l));
    sb.push_back({2'(l), d});
    cyc();
  endtask

  task automatic rst_chk();
    chk("rst_ready", req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_tx_req", 32'(m_tx_req), 0);
    chk("rst_tx_data", m_tx_data, 0);
    chk("rst_grant", grant_id, 0);
  endtask

  initial begin
    vecs[0]  = '{4'hF, 32'h13121110, 0};
    vecs[1]  = '{4'hF, 32'h23222120, 1};
    vecs[2]  = '{4'hF, 32'h33323130, 2};
    vecs[3]  = '{4'hF, 32'h43424140, 3};
    vecs[4]  = '{4'hF, 32'h53525150, 0};
    vecs[5]  = '{4'hA, 32'h63626160, 1};
    vecs[6]  = '{4'h1, 32'h73727170, 0};
    vecs[7]  = '{4'h9, 32'h83828180, 3};
    vecs[8]  = '{4'h9, 32'h93929190, 0};
    vecs[9]  = '{4'h6, 32'hA3A2A1A0, 1};
    vecs[10] = '{4'h6, 32'hB3B2B1B0, 2};
    req_valid = 4'hF;
    repeat (3) cyc();
    #1;
    rst_chk();
    rst = 1'b1;
    req_valid = '0;
    cyc();
    foreach (vecs[i]) begin
      req_valid = vecs[i].valid;
      req_data = vecs[i].data;
      req_last = 4'hF;
      accept(vecs[i].exp_lane, "rr_ready");
      cyc();
      req_valid = '0;
      wait_done(vecs[i].exp_lane, 20, n);
    end
    busy_len = 20;
    set_lane(2, 1'b1, 8'hA5, 1'b1);
    accept(2, "single_ready");
    cyc();
    req_valid = '0;
    chk("single_tx_req", 32'(m_tx_req), 1);
    chk("single_tx_data", m_tx_data, 8'hA5);
    wait_done(2, 40, n);
    chk("single_done_delay", n, 22);
    chk("single_ptr", 32'(dut.ptr), 2);
    chk("single_idle", 32'(active), 0);
    busy_len = 3;
    set_lane(0, 1'b1, 8'h70, 1'b1);
    accept(0, "pre_lock_ready");
    cyc();
    req_valid = '0;
    wait_done(0, 20, n);
    set_lane(0, 1'b1, 8'h77, 1'b1);
    set_lane(1, 1'b1, 8'h11, 1'b0);
    accept(1, "lock_first");
    cyc();
    xfer(1, 8'h22, 1'b0, 20);
    xfer(1, 8'h33, 1'b1, 20);
    req_valid[1] = 1'b0;
    wait_done(1, 20, n);
    accept(0, "after_lock");
    cyc();
    req_valid = '0;
    wait_done(0, 20, n);
    model_on = 1'b0;
    set_lane(1, 1'b1, 8'h5E, 1'b1);
    accept(1, "to_ready");
    cyc();
    req_valid = '0;
    chk("to_tx_req", 32'(m_tx_req), 1);
    n = 0;
    dn = 0;
    while (!err && n < 40) begin
      cyc();
      n++;
      if (done != 0) dn = 1;
    end
    chk("to_err_delay", n, 17);
    chk("to_no_done", dn, 0);
    chk("to_idle", 32'(active), 0);
    model_on = 1'b1;
    set_lane(0, 1'b1, 8'h0F, 1'b1);
    set_lane(1, 1'b1, 8'h5F, 1'b1);
    accept(0, "after_timeout");
    cyc();
    req_valid = '0;
    wait_done(0, 20, n);
    busy_len = 20;
    set_lane(2, 1'b1, 8'hC4, 1'b0);
    accept(2, "rst_pkt_ready");
    cyc();
    n = 0;
    while (!m_busy && n < 10) begin
      cyc();
      n++;
    end
    chk("rst_busy_seen", 32'(m_busy), 1);
    cyc();
    rst = 1'b0;
    req_valid = 4'b1101;
    cyc();
    #1;
    rst_chk();
    busy_len = 3;
    rst = 1'b1;
    accept(0, "post_rst_ready");
    cyc();
    req_valid = '0;
    wait_done(0, 20, n);
    set_lane(3, 1'b1, 8'h3A, 1'b0);
    accept(3, "hold_first");
    cyc();
    req_valid[3] = 1'b0;
    set_lane(0, 1'b1, 8'hA0, 1'b1);
    set_lane(1, 1'b1, 8'hA1, 1'b1);
    wait_done(3, 20, n);
    repeat (10) begin
      #1;
      chk("stall_active", 32'(active), 1);
      chk("stall_tx_req", 32'(m_tx_req), 0);
      chk("stall_ready", req_ready, 0);
      cyc();
    end
    set_lane(3, 1'b1, 8'h3B, 1'b1);
    accept(3, "hold_resume");
    cyc();
    req_valid[3] = 1'b0;
    wait_done(3, 20, n);
    accept(0, "after_hold");
    cyc();
    req_valid = '0;
    wait_done(0, 20, n);
    repeat (3) cyc();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
